// File: rtl/vram_write_scheduler_pkg.sv
// Shared constants, enums and the VRAM address decode helper for the write scheduler.
package gpu_vram_pkg;

   localparam logic [15:0] TILE_BASE  = 16'h0000;
   localparam logic [15:0] ATTR_BASE  = 16'h0800;
   localparam logic [15:0] COLOR_BASE = 16'h1800;

   localparam int TILE_AW  = 11;
   localparam int ATTR_AW  = 12;
   localparam int COLOR_AW = 4;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fill_state_e;
   typedef enum logic {BUS = 1'b0, FILL = 1'b1} grant_src_e;
   typedef enum logic [1:0] {TGT_TILE = 2'd0, TGT_ATTR = 2'd1, TGT_COLOR = 2'd2} target_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   function automatic target_e decode_target(input logic [15:0] a);
      if (a < ATTR_BASE) begin
         return TGT_TILE;
      end else if (a < COLOR_BASE) begin
         return TGT_ATTR;
      end else begin
         return TGT_COLOR;
      end
   endfunction

endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU-side bus write handshake between the bus front end and the write scheduler.
interface vram_write_scheduler_if #(parameter int ADDR_W = 16);
   logic              bus_wr_valid;
   logic [ADDR_W-1:0] bus_wr_addr;
   logic [7:0]        bus_wr_data;
   logic              bus_wr_ready;

   modport master (output bus_wr_valid, output bus_wr_addr, output bus_wr_data, input bus_wr_ready);
   modport slave  (input bus_wr_valid, input bus_wr_addr, input bus_wr_data, output bus_wr_ready);
endinterface

// File: rtl/vram_write_scheduler_fifo.sv
// Synchronous bus-write FIFO holding {addr, data} entries; a push while full is dropped.
module vram_wr_fifo
   import gpu_vram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  wr_entry_t              i_push_data,
   input  logic                   i_pop,
   output wr_entry_t              o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wr_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == {CNT_W{1'b0}});
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Entry storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates buffered bus writes against the fill engine onto the tile/attribute/color ports.
// Optional per-source write counters are enabled with VRAM_SCHED_STATS_EN.
module vram_write_scheduler
   import gpu_vram_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   vram_write_scheduler_if.slave bus,
   input  logic                fill_start,
   input  logic [ADDR_W-1:0]   fill_base,
   input  logic [15:0]         fill_len,
   input  logic [7:0]          fill_value,
   output logic                fill_busy,
   output logic                fill_done,
   output logic                tile_memory_write_enable,
   output logic [TILE_AW-1:0]  tile_memory_write_addr,
   output logic [7:0]          tile_memory_write_data,
   output logic                attribute_memory_write_enable,
   output logic [ATTR_AW-1:0]  attribute_memory_write_addr,
   output logic [7:0]          attribute_memory_write_data,
   output logic                color_memory_write_enable,
   output logic [COLOR_AW-1:0] color_memory_write_addr,
   output logic [7:0]          color_memory_write_data
`ifdef VRAM_SCHED_STATS_EN
   ,
   output logic [15:0]         bus_write_count,
   output logic [15:0]         fill_write_count
`endif
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             w_push;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   wr_entry_t        w_push_entry;
   wr_entry_t        w_fifo_head;

   fill_state_e      r_fill_state;
   fill_state_e      w_fill_state_nxt;
   logic [ADDR_W-1:0] r_fill_addr;
   logic [15:0]      r_fill_rem;
   logic [7:0]       r_fill_value;
   logic             r_fill_busy;
   logic             r_fill_done;
   logic             w_fill_done_nxt;
   logic             w_fill_last;

   grant_src_e       r_last_grant;
   logic             w_grant_bus;
   logic             w_grant_fill;
   logic             w_wr_valid;
   logic [15:0]      w_wr_addr;
   logic [7:0]       w_wr_data;
   logic [ATTR_AW-1:0] w_attr_off;

   logic               r_tile_we;
   logic [TILE_AW-1:0] r_tile_addr;
   logic [7:0]         r_tile_data;
   logic               r_attr_we;
   logic [ATTR_AW-1:0] r_attr_addr;
   logic [7:0]         r_attr_data;
   logic               r_color_we;
   logic [COLOR_AW-1:0] r_color_addr;
   logic [7:0]         r_color_data;

   assign w_push           = bus.bus_wr_valid && !w_fifo_full;
   assign bus.bus_wr_ready = (w_fifo_count < CNT_W'(FIFO_DEPTH));
   assign w_push_entry     = '{addr: bus.bus_wr_addr, data: bus.bus_wr_data};

   vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_grant_bus),
      .o_head      (w_fifo_head),
      .o_count     (w_fifo_count),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   // Round-robin on ties: the source that did not win last time goes first.
   always_comb begin
      w_grant_bus  = 1'b0;
      w_grant_fill = 1'b0;
      if (!w_fifo_empty && (r_fill_state == RUN)) begin
         w_grant_bus  = (r_last_grant == FILL);
         w_grant_fill = (r_last_grant == BUS);
      end else begin
         w_grant_bus  = !w_fifo_empty;
         w_grant_fill = (r_fill_state == RUN);
      end
   end

   assign w_wr_valid  = w_grant_bus || w_grant_fill;
   assign w_wr_addr   = w_grant_fill ? 16'(r_fill_addr) : w_fifo_head.addr;
   assign w_wr_data   = w_grant_fill ? r_fill_value : w_fifo_head.data;
   assign w_fill_last = w_grant_fill && (r_fill_rem == 16'd1);
   assign w_attr_off  = w_wr_addr[ATTR_AW-1:0] - ATTR_BASE[ATTR_AW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill_state <= IDLE;
      end else begin
         r_fill_state <= w_fill_state_nxt;
      end
   end

   always_comb begin
      w_fill_state_nxt = r_fill_state;
      case (r_fill_state)
         IDLE: begin
            if (fill_start && (fill_len != 16'd0)) begin
               w_fill_state_nxt = RUN;
            end else begin
               w_fill_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_fill_last) begin
               w_fill_state_nxt = IDLE;
            end else begin
               w_fill_state_nxt = RUN;
            end
         end
         default: w_fill_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_fill_done_nxt = 1'b0;
      case (r_fill_state)
         IDLE:    w_fill_done_nxt = fill_start && (fill_len == 16'd0);
         RUN:     w_fill_done_nxt = w_fill_last;
         default: w_fill_done_nxt = 1'b0;
      endcase
   end

   // Fill datapath: latch parameters on an accepted start, advance on each fill grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill_addr  <= {ADDR_W{1'b0}};
         r_fill_rem   <= 16'd0;
         r_fill_value <= 8'd0;
         r_fill_busy  <= 1'b0;
         r_fill_done  <= 1'b0;
      end else begin
         r_fill_busy <= (w_fill_state_nxt == RUN);
         r_fill_done <= w_fill_done_nxt;
         if ((r_fill_state == IDLE) && fill_start) begin
            r_fill_addr  <= fill_base;
            r_fill_rem   <= fill_len;
            r_fill_value <= fill_value;
         end else if (w_grant_fill) begin
            r_fill_addr <= r_fill_addr + ADDR_W'(1);
            r_fill_rem  <= r_fill_rem - 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= FILL;
      end else if (w_grant_bus) begin
         r_last_grant <= BUS;
      end else if (w_grant_fill) begin
         r_last_grant <= FILL;
      end
   end

   // Registered decode; unselected ports keep their last address and data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tile_we    <= 1'b0;
         r_tile_addr  <= {TILE_AW{1'b0}};
         r_tile_data  <= 8'd0;
         r_attr_we    <= 1'b0;
         r_attr_addr  <= {ATTR_AW{1'b0}};
         r_attr_data  <= 8'd0;
         r_color_we   <= 1'b0;
         r_color_addr <= {COLOR_AW{1'b0}};
         r_color_data <= 8'd0;
      end else begin
         r_tile_we  <= 1'b0;
         r_attr_we  <= 1'b0;
         r_color_we <= 1'b0;
         if (w_wr_valid) begin
            case (decode_target(w_wr_addr))
               TGT_TILE: begin
                  r_tile_we   <= 1'b1;
                  r_tile_addr <= w_wr_addr[TILE_AW-1:0];
                  r_tile_data <= w_wr_data;
               end
               TGT_ATTR: begin
                  r_attr_we   <= 1'b1;
                  r_attr_addr <= w_attr_off;
                  r_attr_data <= w_wr_data;
               end
               TGT_COLOR: begin
                  r_color_we   <= 1'b1;
                  r_color_addr <= w_wr_addr[COLOR_AW-1:0];
                  r_color_data <= w_wr_data;
               end
               default: begin
                  r_tile_we <= 1'b0;
               end
            endcase
         end
      end
   end

   assign fill_busy                     = r_fill_busy;
   assign fill_done                     = r_fill_done;
   assign tile_memory_write_enable      = r_tile_we;
   assign tile_memory_write_addr        = r_tile_addr;
   assign tile_memory_write_data        = r_tile_data;
   assign attribute_memory_write_enable = r_attr_we;
   assign attribute_memory_write_addr   = r_attr_addr;
   assign attribute_memory_write_data   = r_attr_data;
   assign color_memory_write_enable     = r_color_we;
   assign color_memory_write_addr       = r_color_addr;
   assign color_memory_write_data       = r_color_data;

`ifdef VRAM_SCHED_STATS_EN
   logic [15:0] r_bus_cnt;
   logic [15:0] r_fill_cnt;

   // Saturating per-source grant counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bus_cnt  <= 16'd0;
         r_fill_cnt <= 16'd0;
      end else begin
         if (w_grant_bus && (r_bus_cnt != 16'hFFFF)) begin
            r_bus_cnt <= r_bus_cnt + 16'd1;
         end
         if (w_grant_fill && (r_fill_cnt != 16'hFFFF)) begin
            r_fill_cnt <= r_fill_cnt + 16'd1;
         end
      end
   end

   assign bus_write_count  = r_bus_cnt;
   assign fill_write_count = r_fill_cnt;
`endif

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed plus random bench for vram_write_scheduler against a queue-based reference model.
module tb_vram_write_scheduler;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fill_start;
   logic [15:0] fill_base;
   logic [15:0] fill_len;
   logic [7:0]  fill_value;
   logic        fill_busy, fill_done;
   logic        t_we, a_we, c_we;
   logic [10:0] t_addr;
   logic [11:0] a_addr;
   logic [3:0]  c_addr;
   logic [7:0]  t_data, a_data, c_data;
`ifdef VRAM_SCHED_STATS_EN
   logic [15:0] bus_cnt, fill_cnt;
`endif

   int n_asserts = 0;
   int n_fails   = 0;

   vram_write_scheduler_if bus_if ();

   vram_write_scheduler #(.FIFO_DEPTH(DEPTH), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus_if),
      .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .tile_memory_write_enable(t_we), .tile_memory_write_addr(t_addr), .tile_memory_write_data(t_data),
      .attribute_memory_write_enable(a_we), .attribute_memory_write_addr(a_addr),
      .attribute_memory_write_data(a_data),
      .color_memory_write_enable(c_we), .color_memory_write_addr(c_addr), .color_memory_write_data(c_data)
`ifdef VRAM_SCHED_STATS_EN
      , .bus_write_count(bus_cnt), .fill_write_count(fill_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state
   typedef struct {logic [15:0] a; logic [7:0] d;} ent_t;
   ent_t        mq[$];
   bit          m_busy, m_last_fill;
   logic [15:0] m_addr;
   int          m_rem;
   logic [7:0]  m_val;
   logic        e_twe, e_awe, e_cwe, e_busy, e_done;
   logic [10:0] e_tad;
   logic [11:0] e_aad;
   logic [3:0]  e_cad;
   logic [7:0]  e_tdat, e_adat, e_cdat;
   int          e_bcnt, e_fcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mwrite(input logic [15:0] a, input logic [7:0] d);
      int ai;
      ai = int'(a);
      if (ai < 2048) begin
         e_twe = 1'b1; e_tad = 11'(ai); e_tdat = d;
      end else if (ai < 6144) begin
         e_awe = 1'b1; e_aad = 12'(ai - 2048); e_adat = d;
      end else begin
         e_cwe = 1'b1; e_cad = 4'(ai % 16); e_cdat = d;
      end
   endtask

   task automatic model_edge();
      bit   was_busy, gb, gf;
      int   was_size;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_busy = 0; m_last_fill = 1; m_addr = 16'd0; m_rem = 0; m_val = 8'd0;
         e_twe = 0; e_awe = 0; e_cwe = 0; e_busy = 0; e_done = 0;
         e_tad = 0; e_aad = 0; e_cad = 0; e_tdat = 0; e_adat = 0; e_cdat = 0;
         e_bcnt = 0; e_fcnt = 0;
         return;
      end
      was_busy = m_busy;
      was_size = mq.size();
      gb = 0; gf = 0;
      if (was_size > 0 && was_busy) begin
         if (m_last_fill) gb = 1; else gf = 1;
      end else if (was_size > 0) gb = 1;
      else if (was_busy) gf = 1;
      e_twe = 0; e_awe = 0; e_cwe = 0; e_done = 0;
      if (gb) begin
         e = mq.pop_front();
         mwrite(e.a, e.d);
         m_last_fill = 0;
         if (e_bcnt < 65535) e_bcnt++;
      end
      if (gf) begin
         mwrite(m_addr, m_val);
         m_addr = m_addr + 16'd1;
         m_rem--;
         m_last_fill = 1;
         if (e_fcnt < 65535) e_fcnt++;
         if (m_rem == 0) begin m_busy = 0; e_done = 1; end
      end
      if (fill_start && !was_busy) begin
         if (fill_len == 16'd0) e_done = 1;
         else begin
            m_busy = 1; m_addr = fill_base; m_rem = int'(fill_len); m_val = fill_value;
         end
      end
      if (bus_if.bus_wr_valid && was_size < DEPTH)
         mq.push_back('{bus_if.bus_wr_addr, bus_if.bus_wr_data});
      e_busy = m_busy;
   endtask

   task automatic check_all();
      chk("tile_we", t_we, e_twe);
      chk("tile_addr", t_addr, e_tad);
      chk("tile_data", t_data, e_tdat);
      chk("attr_we", a_we, e_awe);
      chk("attr_addr", a_addr, e_aad);
      chk("attr_data", a_data, e_adat);
      chk("color_we", c_we, e_cwe);
      chk("color_addr", c_addr, e_cad);
      chk("color_data", c_data, e_cdat);
      chk("fill_busy", fill_busy, e_busy);
      chk("fill_done", fill_done, e_done);
      chk("bus_ready", bus_if.bus_wr_ready, (mq.size() < DEPTH));
`ifdef VRAM_SCHED_STATS_EN
      chk("bus_count", bus_cnt, e_bcnt);
      chk("fill_count", fill_cnt, e_fcnt);
`endif
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d);
      bus_if.bus_wr_valid = 1'b1; bus_if.bus_wr_addr = a; bus_if.bus_wr_data = d;
   endtask

   int n_t, n_a;

   initial begin
      rst = 1'b1; fill_start = 1'b0; fill_base = 16'd0; fill_len = 16'd0; fill_value = 8'd0;
      bus_if.bus_wr_valid = 1'b0; bus_if.bus_wr_addr = 16'd0; bus_if.bus_wr_data = 8'd0;
      cycle(); cycle();
      chk("reset_busy", fill_busy, 1'b0);
      chk("reset_ready", bus_if.bus_wr_ready, 1'b1);
      rst = 1'b0;

      // Single tile write: strobe two edges after the valid edge
      push(16'h0123, 8'hAA); cycle();
      bus_if.bus_wr_valid = 1'b0; cycle();
      chk("t1_tile_we", t_we, 1'b1);
      chk("t1_tile_addr", t_addr, 11'h123);
      chk("t1_tile_data", t_data, 8'hAA);
      chk("t1_others", {a_we, c_we}, 2'b00);
      cycle();
      chk("t1_tile_we_drop", t_we, 1'b0);

      // Attribute boundaries and color alias
      push(16'h0800, 8'h11); cycle();
      push(16'h17FF, 8'h22); cycle();
      chk("t2_attr_lo", {a_we, a_addr}, {1'b1, 12'h000});
      push(16'h1805, 8'h33); cycle();
      bus_if.bus_wr_valid = 1'b0;
      chk("t2_attr_hi", {a_we, a_addr}, {1'b1, 12'hFFF});
      cycle();
      chk("t2_color", {c_we, c_addr, c_data}, {1'b1, 4'h5, 8'h33});
      repeat (3) cycle();

      // Overfill the FIFO while a long fill halves the drain rate
      fill_start = 1'b1; fill_base = 16'h2000; fill_len = 16'd40; fill_value = 8'h5A; cycle();
      fill_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         push(16'h0200 + 16'(i), 8'(i)); cycle();
      end
      bus_if.bus_wr_valid = 1'b0;
      for (int i = 0; i < 200 && fill_busy; i++) cycle();
      chk("t3_fill_drained", fill_busy, 1'b0);
      repeat (6) cycle();

      // Fill wrapping 0xFFFF -> 0x0000 with an idle bus
      fill_start = 1'b1; fill_base = 16'hFFFE; fill_len = 16'd3; fill_value = 8'h11; cycle();
      fill_start = 1'b0;
      chk("t4_busy", fill_busy, 1'b1);
      cycle(); chk("t4_w0", {c_we, c_addr, c_data}, {1'b1, 4'hE, 8'h11});
      cycle(); chk("t4_w1", {c_we, c_addr}, {1'b1, 4'hF});
      cycle(); chk("t4_w2", {t_we, t_addr, fill_done}, {1'b1, 11'h000, 1'b1});
      chk("t4_busy_drop", fill_busy, 1'b0);
      cycle(); chk("t4_done_drop", fill_done, 1'b0);

      // Fill of 4 against a continuous bus stream, started together with a push
      n_t = 0; n_a = 0;
      fill_start = 1'b1; fill_base = 16'h0900; fill_len = 16'd4; fill_value = 8'h77;
      for (int i = 0; i < 24; i++) begin
         if (i < 8) push(16'h0100 + 16'(i), 8'(8'h80 + i)); else bus_if.bus_wr_valid = 1'b0;
         cycle();
         fill_start = 1'b0;
         n_t += int'(t_we); n_a += int'(a_we);
         if (fill_done) begin
            chk("t5_bus_grants", n_t, 4);
            chk("t5_fill_grants", n_a, 4);
            break;
         end
      end
      chk("t5_done_seen", n_a, 4);
      bus_if.bus_wr_valid = 1'b0;
      repeat (8) cycle();

      // Zero-length fill
      fill_start = 1'b1; fill_len = 16'd0; cycle();
      fill_start = 1'b0;
      chk("t6_done", {fill_done, fill_busy, t_we, a_we, c_we}, 5'b10000);
      cycle(); chk("t6_done_drop", fill_done, 1'b0);

      // Reset mid-fill
      fill_start = 1'b1; fill_base = 16'h0000; fill_len = 16'd20; fill_value = 8'h42; cycle();
      fill_start = 1'b0; cycle(); cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      chk("t7_busy", fill_busy, 1'b0);
      repeat (5) begin
         cycle();
         chk("t7_quiet", {fill_done, t_we, a_we, c_we}, 4'b0000);
      end

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         bus_if.bus_wr_valid = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: bus_if.bus_wr_addr = 16'($urandom_range(0, 16'h07FF));
            1: bus_if.bus_wr_addr = 16'($urandom_range(16'h0800, 16'h17FF));
            2: bus_if.bus_wr_addr = 16'($urandom_range(16'h1800, 16'hFFFF));
            default: bus_if.bus_wr_addr = 16'h07FE + 16'($urandom_range(0, 3));
         endcase
         bus_if.bus_wr_data = 8'($urandom);
         fill_start = ($urandom_range(0, 14) == 0);
         fill_base = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
         fill_len = 16'($urandom_range(0, 7));
         fill_value = 8'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Shares the GPU's three write-only memory ports (tile, attribute, color) between two requesters:
  - CPU-side bus writes, buffered in a small FIFO.
  - A hardware fill engine that writes a constant byte over a VRAM address range, used for screen clear and attribute fill.
- Decodes the 16-bit VRAM address into the target memory and drives single-cycle write strobes.
- Sits between the CPU bus front end and the tile/attribute/color memories.

Parameters:
- FIFO_DEPTH, 4, bus-write FIFO entries; power of two, minimum 2.
- ADDR_W, 16, VRAM address width.

Ports:
- clk  input  1  GPU system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_wr_valid  input  1  bus write request.
- bus_wr_addr  input  16  bus write VRAM address.
- bus_wr_data  input  8  bus write byte.
- bus_wr_ready  output  1  FIFO not full; a push happens when valid && ready.
- fill_start  input  1  one-cycle pulse that starts the fill engine.
- fill_base  input  16  first fill address, sampled on start.
- fill_len  input  16  number of bytes to fill, sampled on start.
- fill_value  input  8  fill byte, sampled on start.
- fill_busy  output  1  fill engine is running.
- fill_done  output  1  one-cycle pulse when a fill completes.
- tile_memory_write_enable  output  1  tile memory write strobe.
- tile_memory_write_addr  output  11  tile memory write address.
- tile_memory_write_data  output  8  tile memory write data.
- attribute_memory_write_enable  output  1  attribute memory write strobe.
- attribute_memory_write_addr  output  12  attribute memory write address.
- attribute_memory_write_data  output  8  attribute memory write data.
- color_memory_write_enable  output  1  color memory write strobe.
- color_memory_write_addr  output  4  color memory write address.
- color_memory_write_data  output  8  color memory write data.

Behaviour:
- Reset: all outputs 0, FIFO empty, fill FSM IDLE, last_grant = FILL so the bus wins the first tie.
- bus_wr_ready = !full, registered-free (derived from the FIFO count).
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - There is no bypass: an entry pushed at edge N can be granted at edge N+1 at the earliest.
- Fill FSM:
  - IDLE: on fill_start, latch base, len and value. If len==0, pulse fill_done at the next edge and stay IDLE. Otherwise go to RUN and assert fill_busy.
  - RUN: each granted fill slot writes value at cur_addr, then cur_addr+1 with 16-bit wrap (0xFFFF->0x0000) and remaining-1.
  - When the last byte is granted, go to IDLE and pulse fill_done at that same edge; fill_busy drops at that edge.
  - fill_start while busy is ignored.
- Arbitration at each edge, between FIFO non-empty and fill RUN:
  - If only one is pending, grant it.
  - If both are pending, grant the one opposite to last_grant, then update last_grant.
  - At most one write is granted per cycle.
- Decode of the granted address a. Outputs are registered, so the strobe is high for exactly the one cycle after the grant edge and all enables are 0 on idle cycles.
  - a < 0x0800: tile port, addr = a[10:0].
  - 0x0800 <= a < 0x1800: attribute port, addr = (a - 0x0800)[11:0].
  - a >= 0x1800: color port, addr = a[3:0] (aliases).
- Unselected ports hold their previous addr/data values with enable 0.
- Latency: an idle-bus write accepted at edge N shows its strobe during the cycle after edge N+1.
- Reset mid-fill aborts the fill with no fill_done pulse; reset discards FIFO contents.
- Simultaneous fill_start and bus push are both accepted in the same cycle.

Optional Feature:
- Macro VRAM_SCHED_STATS_EN.
- When defined, adds two outputs, bus_write_count[15:0] and fill_write_count[15:0]:
  - Each increments once per granted write of that source.
  - Both saturate at 0xFFFF and clear on rst.
- When undefined, the ports and counters do not exist and the remaining behaviour is identical.

Decomposition:
- Package gpu_vram_pkg holds:
  - Constants TILE_BASE=0x0000, ATTR_BASE=0x0800, COLOR_BASE=0x1800.
  - Widths TILE_AW=11, ATTR_AW=12, COLOR_AW=4.
  - An enum for the fill states IDLE/RUN and the grant source BUS/FILL.
- Sub-module vram_wr_fifo:
  - Synchronous FIFO with a 24-bit entry {addr, data}.
  - Provides count, full and empty.
- Arbiter, fill FSM and decode stay in the top module.

Test Plan:
- Reset, then a single bus write 0x0123/0xAA -> tile_memory_write_enable high for one cycle with addr 0x123, data 0xAA, 2 cycles after the valid edge; other enables 0.
- Bus writes to 0x0800, 0x17FF, 0x1805 -> attribute addr 0x000 and 0xFFF, then color addr 0x5.
- Push 5 writes back-to-back with FIFO_DEPTH=4 and no drain possible -> bus_wr_ready low after 4 entries; the 5th is not stored.
- fill_start with base 0xFFFE, len 3, value 0x11 and the bus idle -> color writes at 0xE, 0xF, then tile addr 0x000 on consecutive cycles; fill_done pulses with the third grant.
- Fill of len 4 with a continuous bus stream -> grants alternate BUS, FILL, BUS, FILL…; fill completes after 8 grants.
- fill_len 0 -> fill_done one cycle later with no strobes. Separately, rst asserted mid-fill -> busy 0, no fill_done, no further strobes.
